// File: rtl/aes_encipher_round_engine_pkg.sv
// Shared AES encipher constants: key-length encodings, round counts, FSM states,
// state-update kinds and the byte/word transforms used by the round datapath.
package aes_pkg;

    localparam logic [1:0] KEYLEN_128 = 2'd0;
    localparam logic [1:0] KEYLEN_256 = 2'd1;
    localparam logic [1:0] KEYLEN_192 = 2'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_SBOX = 2'd2;
    localparam logic [1:0] ST_MAIN = 2'd3;

    typedef enum logic [2:0] {
        UPD_NO,
        UPD_INIT,
        UPD_SBOX,
        UPD_MAIN,
        UPD_FINAL
    } upd_t;

    // The reserved encoding falls back to the 128-bit schedule.
    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            KEYLEN_256: return NR_256;
            KEYLEN_192: return NR_192;
            default:    return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    // State is column-major: byte (row r, column c) sits at bits 127-8*(4c+r).
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = mixw(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_encipher_round_engine_if.sv
// Bus between the AES core top (key source, block I/O) and the round engine,
// including the S-box lanes. abort exists only when AES_ENC_ABORT_EN is defined.
interface aes_encipher_round_engine_if #(
    parameter int NUM_SBOX_LANES = 1
) ();
    logic                          next;
    logic [1:0]                    keylen;
    logic                          reset_round;
    logic                          new_round;
    logic [3:0]                    round;
    logic [127:0]                  round_key;
    logic [32*NUM_SBOX_LANES-1:0]  sboxw;
    logic [32*NUM_SBOX_LANES-1:0]  new_sboxw;
    logic [127:0]                  block;
    logic [127:0]                  new_block;
    logic                          ready;
    logic                          done;
`ifdef AES_ENC_ABORT_EN
    logic                          abort;

    modport slave (
        input  next, keylen, round_key, new_sboxw, block, abort,
        output reset_round, new_round, round, sboxw, new_block, ready, done
    );
    modport master (
        output next, keylen, round_key, new_sboxw, block, abort,
        input  reset_round, new_round, round, sboxw, new_block, ready, done
    );
`else
    modport slave (
        input  next, keylen, round_key, new_sboxw, block,
        output reset_round, new_round, round, sboxw, new_block, ready, done
    );
    modport master (
        output next, keylen, round_key, new_sboxw, block,
        input  reset_round, new_round, round, sboxw, new_block, ready, done
    );
`endif
endinterface

// File: rtl/aes_encipher_round_engine_dp.sv
// Combinational round datapath: AddRoundKey for the initial round, plus
// ShiftRows/MixColumns/AddRoundKey candidates for main and final rounds.
module aes_enc_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] init_block,
    output logic [127:0] main_block,
    output logic [127:0] final_block
);
    logic [127:0] shifted;

    assign shifted     = shiftrows(state);
    assign init_block  = block ^ round_key;
    assign main_block  = mixcolumns(shifted) ^ round_key;
    assign final_block = shifted ^ round_key;
endmodule

// File: rtl/aes_encipher_round_engine.sv
// Iterative AES encipher round FSM with NUM_SBOX_LANES words substituted per cycle.
// Optional AES_ENC_ABORT_EN adds an abort input that cancels a running block.
module aes_encipher_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_SBOX_LANES = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    aes_encipher_round_engine_if.slave  bus
);
    localparam int         GROUPS     = 4 / NUM_SBOX_LANES;
    localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);

    generate
        if (!(NUM_SBOX_LANES == 1 || NUM_SBOX_LANES == 2 || NUM_SBOX_LANES == 4)) begin : g_bad_lanes
            $error("NUM_SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]   state_q, state_d;
    logic [1:0]   keylen_q, keylen_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic [127:0] new_block_q, new_block_d;
    logic         ready_q, ready_d;
    logic         done_q, done_d;

    logic         reset_round;
    logic         new_round;
    logic         abort_req;
    logic [3:0]   nr;
    upd_t         upd;
    logic [127:0] init_block, main_block, final_block, sbox_block;
    logic [32*NUM_SBOX_LANES-1:0] sboxw;

`ifdef AES_ENC_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign nr = num_rounds(keylen_q);

    aes_enc_round_dp u_dp (
        .state       (new_block_q),
        .round_key   (bus.round_key),
        .block       (bus.block),
        .init_block  (init_block),
        .main_block  (main_block),
        .final_block (final_block)
    );

    // Lane j handles state word sword_ctr*NUM_SBOX_LANES + j; word 0 is bits [127:96].
    always_comb begin
        sboxw      = '0;
        sbox_block = new_block_q;
        for (int j = 0; j < NUM_SBOX_LANES; j++) begin
            if (state_q == ST_SBOX) begin
                sboxw[32 * j +: 32] =
                    new_block_q[32 * (3 - (int'(sword_ctr_q) * NUM_SBOX_LANES + j)) +: 32];
            end
            sbox_block[32 * (3 - (int'(sword_ctr_q) * NUM_SBOX_LANES + j)) +: 32] =
                bus.new_sboxw[32 * j +: 32];
        end
    end

    always_comb begin
        state_d     = state_q;
        keylen_d    = keylen_q;
        round_d     = round_q;
        sword_ctr_d = sword_ctr_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        reset_round = 1'b0;
        new_round   = 1'b0;
        upd         = UPD_NO;

        case (state_q)
            ST_IDLE: begin
                if (bus.next) begin
                    reset_round = 1'b1;
                    ready_d     = 1'b0;
                    keylen_d    = bus.keylen;
                    state_d     = ST_INIT;
                end
            end
            ST_INIT: begin
                upd         = UPD_INIT;
                new_round   = 1'b1;
                round_d     = 4'd1;
                sword_ctr_d = '0;
                state_d     = ST_SBOX;
            end
            ST_SBOX: begin
                upd = UPD_SBOX;
                if (sword_ctr_q == LAST_GROUP) begin
                    sword_ctr_d = '0;
                    state_d     = ST_MAIN;
                end else begin
                    sword_ctr_d = sword_ctr_q + 2'd1;
                end
            end
            default: begin
                new_round = 1'b1;
                if (round_q < nr) begin
                    upd     = UPD_MAIN;
                    round_d = round_q + 4'd1;
                    state_d = ST_SBOX;
                end else begin
                    upd     = UPD_FINAL;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        case (upd)
            UPD_INIT:  new_block_d = init_block;
            UPD_SBOX:  new_block_d = sbox_block;
            UPD_MAIN:  new_block_d = main_block;
            UPD_FINAL: new_block_d = final_block;
            default:   new_block_d = new_block_q;
        endcase

        // Abort beats every update, including the final one, so no partial result escapes.
        if (abort_req && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            done_d      = 1'b0;
            round_d     = '0;
            sword_ctr_d = '0;
            new_block_d = '0;
            new_round   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            keylen_q    <= KEYLEN_128;
            round_q     <= '0;
            sword_ctr_q <= '0;
            new_block_q <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            keylen_q    <= keylen_d;
            round_q     <= round_d;
            sword_ctr_q <= sword_ctr_d;
            new_block_q <= new_block_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.reset_round = reset_round;
    assign bus.new_round   = new_round;
    assign bus.round       = round_q;
    assign bus.sboxw       = sboxw;
    assign bus.new_block   = new_block_q;
    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
endmodule
